// File: rtl/mcu_debug_responder_if.sv
// Debug command channel between debug controller (master) and MCU responder (slave).
// Command is a one-cycle dbg_valid strobe; dbg_busy blocks new commands until completion.
interface mcu_debug_responder_if;
  logic        dbg_valid;
  logic [3:0]  dbg_fn;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_d_in;
  logic        dbg_busy;
  logic [31:0] dbg_d_rd;
  logic        dbg_error;
  logic        dbg_halted;

  modport master (
    output dbg_valid, dbg_fn, dbg_addr, dbg_d_in,
    input  dbg_busy, dbg_d_rd, dbg_error, dbg_halted
  );

  modport slave (
    input  dbg_valid, dbg_fn, dbg_addr, dbg_d_in,
    output dbg_busy, dbg_d_rd, dbg_error, dbg_halted
  );
endinterface

// File: rtl/mcu_debug_responder.sv
// MCU debug responder: maps debug commands onto core hold/reset, RF and data-memory debug ports.
// Latency: busy from accept+1 until completion; commands arriving while busy are dropped.
// Optional DBG_RESP_TIMEOUT_EN bounds MEM_WAIT and DRAIN by MEM_TIMEOUT cycles.
module mcu_debug_responder #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mcu_debug_responder_if.slave  dbg,
  input  logic                  cpu_idle,
  output logic                  cpu_hold,
  output logic                  cpu_reset,
  output logic [4:0]            rf_addr,
  output logic [31:0]           rf_wd,
  output logic                  rf_we,
  input  logic [31:0]           rf_rd,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wd,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_HALTED, S_STEP_REL, S_RF_ACC, S_MEM_WAIT, S_RST
  } state_t;

  localparam logic [3:0] FN_NONE   = 4'd0;
  localparam logic [3:0] FN_PAUSE  = 4'd1;
  localparam logic [3:0] FN_RESUME = 4'd2;
  localparam logic [3:0] FN_STEP   = 4'd3;
  localparam logic [3:0] FN_RESET  = 4'd4;
  localparam logic [3:0] FN_MEM_RD = 4'd8;
  localparam logic [3:0] FN_MEM_WR = 4'd9;
  localparam logic [3:0] FN_REG_RD = 4'd10;
  localparam logic [3:0] FN_REG_WR = 4'd11;
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              err_pend_q, err_pend_d;
  logic              halted_q, halted_d;
  logic              hold_q, hold_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              was_halted_q, was_halted_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0]       d_rd_q, d_rd_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [31:0]       rf_wd_q, rf_wd_d;
  logic              rf_we_q, rf_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              tmo_hit;
  logic              is_halted;

`ifdef DBG_RESP_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  // Restarts on every entry to a waiting state, counts while the wait persists.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_MEM_WAIT || state_q == S_DRAIN) && state_d == state_q)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign is_halted = (state_q == S_HALTED);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    err_d        = err_q;
    err_pend_d   = err_pend_q;
    halted_d     = halted_q;
    hold_d       = hold_q;
    cpu_reset_d  = cpu_reset_q;
    was_halted_d = was_halted_q;
    rst_cnt_d    = rst_cnt_q;
    d_rd_d       = d_rd_q;
    rf_addr_d    = rf_addr_q;
    rf_wd_d      = rf_wd_q;
    rf_we_d      = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;

    case (state_q)
      S_RUN, S_HALTED: begin
        // Single-cycle commands stay in RUN/HALTED and finish on the next edge.
        if (busy_q) begin
          busy_d = 1'b0;
          err_d  = err_pend_q;
        end else if (dbg.dbg_valid && dbg.dbg_fn != FN_NONE) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          err_pend_d = 1'b0;
          case (dbg.dbg_fn)
            FN_PAUSE: begin
              if (!is_halted) begin
                state_d = S_DRAIN;
                hold_d  = 1'b1;
              end
            end
            FN_RESUME: begin
              state_d  = S_RUN;
              hold_d   = 1'b0;
              halted_d = 1'b0;
            end
            FN_STEP: begin
              if (is_halted) begin
                state_d  = S_STEP_REL;
                hold_d   = 1'b0;
                halted_d = 1'b0;
              end else begin
                err_pend_d = 1'b1;
              end
            end
            FN_RESET: begin
              state_d      = S_RST;
              cpu_reset_d  = 1'b1;
              was_halted_d = is_halted;
              rst_cnt_d    = RST_W'(RST_CYCLES - 1);
            end
            FN_REG_RD, FN_REG_WR: begin
              if (is_halted) begin
                state_d   = S_RF_ACC;
                rf_addr_d = dbg.dbg_addr[4:0];
                if (dbg.dbg_fn == FN_REG_WR) begin
                  rf_wd_d = dbg.dbg_d_in;
                  rf_we_d = 1'b1;
                end
              end else begin
                err_pend_d = 1'b1;
              end
            end
            FN_MEM_RD, FN_MEM_WR: begin
              if (is_halted && dbg.dbg_addr[1:0] == 2'b00) begin
                state_d    = S_MEM_WAIT;
                mem_addr_d = dbg.dbg_addr;
                mem_wd_d   = dbg.dbg_d_in;
                mem_re_d   = (dbg.dbg_fn == FN_MEM_RD);
                mem_we_d   = (dbg.dbg_fn == FN_MEM_WR);
              end else begin
                err_pend_d = 1'b1;
              end
            end
            default: err_pend_d = 1'b1;
          endcase
        end
      end
      S_DRAIN: begin
        if (cpu_idle || tmo_hit) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
          busy_d   = 1'b0;
          err_d    = !cpu_idle;
        end
      end
      S_STEP_REL: begin
        state_d = S_DRAIN;
        hold_d  = 1'b1;
      end
      S_RF_ACC: begin
        if (!rf_we_q) d_rd_d = rf_rd;
        state_d = S_HALTED;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
      S_MEM_WAIT: begin
        if (mem_ack || tmo_hit) begin
          if (mem_ack && mem_re_q) d_rd_d = mem_rdata;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_HALTED;
          busy_d   = 1'b0;
          err_d    = !mem_ack;
        end
      end
      S_RST: begin
        if (rst_cnt_q == '0) begin
          cpu_reset_d = 1'b0;
          state_d     = was_halted_q ? S_HALTED : S_RUN;
          busy_d      = 1'b0;
          err_d       = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_pend_q   <= 1'b0;
      halted_q     <= 1'b0;
      hold_q       <= 1'b0;
      cpu_reset_q  <= 1'b0;
      was_halted_q <= 1'b0;
      rst_cnt_q    <= '0;
      d_rd_q       <= '0;
      rf_addr_q    <= '0;
      rf_wd_q      <= '0;
      rf_we_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_pend_q   <= err_pend_d;
      halted_q     <= halted_d;
      hold_q       <= hold_d;
      cpu_reset_q  <= cpu_reset_d;
      was_halted_q <= was_halted_d;
      rst_cnt_q    <= rst_cnt_d;
      d_rd_q       <= d_rd_d;
      rf_addr_q    <= rf_addr_d;
      rf_wd_q      <= rf_wd_d;
      rf_we_q      <= rf_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign dbg.dbg_busy   = busy_q;
  assign dbg.dbg_d_rd   = d_rd_q;
  assign dbg.dbg_error  = err_q;
  assign dbg.dbg_halted = halted_q;
  assign cpu_hold       = hold_q;
  assign cpu_reset      = cpu_reset_q;
  assign rf_addr        = rf_addr_q;
  assign rf_wd          = rf_wd_q;
  assign rf_we          = rf_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wd         = mem_wd_q;
  assign mem_re         = mem_re_q;
  assign mem_we         = mem_we_q;

endmodule
